// File: rtl/uc_multicycle_if.sv
// Instruction/data memory request-ready handshake between the multicycle control unit and memory.
interface uc_multicycle_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (output imem_req, output dmem_req, input imem_ready, input dmem_ready);
    modport slave  (input imem_req, input dmem_req, output imem_ready, output dmem_ready);
endinterface

// File: rtl/uc_multicycle.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/write-back over a
// handshaked memory, resolves branches and traps on illegal opcodes or memory timeouts.
module uc_multicycle #(
    parameter int unsigned MEM_TIMEOUT      = 15,
    parameter bit          BRANCH_FUNCT3_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    uc_multicycle_if.master mem,
    input  logic [4:0]     selector,
    input  logic [2:0]     funct3,
    input  logic           Zero,
    input  logic           Lt,
    input  logic           Ltu,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic [1:0]     PCSrc,
    output logic           Branch,
    output logic           Jump,
    output logic [2:0]     ImmSel,
    output logic           LUIOP,
    output logic           ASrcPC,
    output logic           ALUSrc,
    output logic           WDSrc,
    output logic           Mem2Reg,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           RegWriteEn,
    output logic [1:0]     ALUOP,
    output logic           illegal,
    output logic [2:0]     state
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BOOT   = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } iclass_t;

    state_t           state_q, state_d;
    iclass_t          cls_q, dec_class;
    logic             dec_legal;
    logic             taken;
    logic             timed_out;
    logic [CNT_W-1:0] cnt_q;

    assign state     = state_q;
    assign timed_out = (MEM_TIMEOUT != 0) && (cnt_q == CNT_MAX);

    // Opcode class decode; reserved branch funct3 values are illegal in full-resolution mode
    always_comb begin
        dec_legal = 1'b1;
        dec_class = C_R;
        case (selector)
            5'b01100: dec_class = C_R;
            5'b00100: dec_class = C_I;
            5'b00000: dec_class = C_LOAD;
            5'b01000: dec_class = C_STORE;
            5'b11000: begin
                dec_class = C_BRANCH;
                if (BRANCH_FUNCT3_EN && (funct3[2:1] == 2'b01)) dec_legal = 1'b0;
            end
            5'b11011: dec_class = C_JAL;
            5'b11001: dec_class = C_JALR;
            5'b01101: dec_class = C_LUI;
            5'b00101: dec_class = C_AUIPC;
            default:  dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        taken = Zero;
        if (BRANCH_FUNCT3_EN) begin
            case (funct3)
                3'b000:  taken = Zero;
                3'b001:  taken = !Zero;
                3'b100:  taken = Lt;
                3'b101:  taken = !Lt;
                3'b110:  taken = Ltu;
                3'b111:  taken = !Ltu;
                default: taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // Class latch and wait counter; the counter restarts whenever the state changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q <= C_R;
            cnt_q <= '0;
        end else begin
            if (state_q == S_DECODE) cls_q <= dec_class;
            if (state_d != state_q) cnt_q <= '0;
            else if ((state_q == S_FETCH) || (state_q == S_MEM)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCSrc        = 2'b00;
        Branch       = 1'b0;
        Jump         = 1'b0;
        ImmSel       = 3'b000;
        LUIOP        = 1'b0;
        ASrcPC       = 1'b0;
        ALUSrc       = 1'b0;
        WDSrc        = 1'b0;
        Mem2Reg      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWriteEn   = 1'b0;
        ALUOP        = 2'b00;
        illegal      = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        ALUOP   = 2'b10;
                        state_d = S_WB;
                    end
                    C_I: begin
                        ALUSrc  = 1'b1;
                        ALUOP   = 2'b10;
                        state_d = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        ALUSrc  = 1'b1;
                        ImmSel  = (cls_q == C_STORE) ? 3'b001 : 3'b000;
                        state_d = S_MEM;
                    end
                    C_BRANCH: begin
                        ImmSel  = 3'b010;
                        Branch  = 1'b1;
                        ALUOP   = 2'b01;
                        PCWrite = 1'b1;
                        PCSrc   = taken ? 2'b01 : 2'b00;
                        state_d = S_FETCH;
                    end
                    C_JAL, C_JALR: begin
                        ImmSel     = (cls_q == C_JAL) ? 3'b100 : 3'b000;
                        ALUSrc     = (cls_q == C_JALR);
                        Jump       = 1'b1;
                        WDSrc      = 1'b1;
                        RegWriteEn = 1'b1;
                        PCWrite    = 1'b1;
                        PCSrc      = (cls_q == C_JAL) ? 2'b01 : 2'b10;
                        state_d    = S_FETCH;
                    end
                    C_LUI, C_AUIPC: begin
                        ImmSel  = 3'b011;
                        ALUSrc  = 1'b1;
                        LUIOP   = (cls_q == C_LUI);
                        ASrcPC  = (cls_q == C_AUIPC);
                        state_d = S_WB;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                MemRead      = (cls_q == C_LOAD);
                MemWrite     = (cls_q == C_STORE);
                if (mem.dmem_ready) begin
                    if (cls_q == C_STORE) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                RegWriteEn = 1'b1;
                PCWrite    = 1'b1;
                Mem2Reg    = (cls_q == C_LOAD);
                state_d    = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_BOOT;
        endcase
    end
endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle: a full-resolution unit and a legacy-branch unit run in lockstep.
module tb_uc_multicycle;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic       rst_n;
    logic [4:0] selector;
    logic [2:0] funct3;
    logic       Zero, Lt, Ltu;

    logic       IRWrite, PCWrite, Branch, Jump, LUIOP, ASrcPC, ALUSrc, WDSrc;
    logic       Mem2Reg, MemRead, MemWrite, RegWriteEn, illegal;
    logic [1:0] PCSrc, ALUOP;
    logic [2:0] ImmSel, state;

    logic       l_IRWrite, l_PCWrite, l_Branch, l_Jump, l_LUIOP, l_ASrcPC, l_ALUSrc, l_WDSrc;
    logic       l_Mem2Reg, l_MemRead, l_MemWrite, l_RegWriteEn, l_illegal;
    logic [1:0] l_PCSrc, l_ALUOP;
    logic [2:0] l_ImmSel, l_state;

    uc_multicycle_if mif ();
    uc_multicycle_if lif ();
    assign lif.imem_ready = mif.imem_ready;
    assign lif.dmem_ready = mif.dmem_ready;

    uc_multicycle #(.MEM_TIMEOUT(15), .BRANCH_FUNCT3_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif), .selector(selector), .funct3(funct3),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .Branch(Branch), .Jump(Jump), .ImmSel(ImmSel), .LUIOP(LUIOP), .ASrcPC(ASrcPC),
        .ALUSrc(ALUSrc), .WDSrc(WDSrc), .Mem2Reg(Mem2Reg), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWriteEn(RegWriteEn), .ALUOP(ALUOP), .illegal(illegal),
        .state(state)
    );

    uc_multicycle #(.MEM_TIMEOUT(15), .BRANCH_FUNCT3_EN(1'b0)) dut_legacy (
        .clk(clk), .rst_n(rst_n), .mem(lif), .selector(selector), .funct3(funct3),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .IRWrite(l_IRWrite), .PCWrite(l_PCWrite),
        .PCSrc(l_PCSrc), .Branch(l_Branch), .Jump(l_Jump), .ImmSel(l_ImmSel), .LUIOP(l_LUIOP),
        .ASrcPC(l_ASrcPC), .ALUSrc(l_ALUSrc), .WDSrc(l_WDSrc), .Mem2Reg(l_Mem2Reg),
        .MemRead(l_MemRead), .MemWrite(l_MemWrite), .RegWriteEn(l_RegWriteEn),
        .ALUOP(l_ALUOP), .illegal(l_illegal), .state(l_state)
    );

    logic [21:0] ctl;
    assign ctl = {mif.imem_req, mif.dmem_req, IRWrite, PCWrite, PCSrc, Branch, Jump, ImmSel,
                  LUIOP, ASrcPC, ALUSrc, WDSrc, Mem2Reg, MemRead, MemWrite, RegWriteEn,
                  ALUOP, illegal};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; selector = 5'b01100; funct3 = 3'b000;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
        mif.imem_ready = 1'b1; mif.dmem_ready = 1'b1;
        #12;
        tests++;
        if ({state, ctl} !== {3'd5, 22'd0}) begin
            fails++; $display("FAIL reset_state: got %b want %b", {state, ctl}, {3'd5, 22'd0});
        end
        tick;
        tests++;
        if ({state, ctl} !== {3'd5, 22'd0}) begin
            fails++; $display("FAIL reset_held: got %b want %b", {state, ctl}, {3'd5, 22'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype;
        tick;
        tests++;
        if ({state, mif.imem_req, IRWrite, RegWriteEn} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            fails++; $display("FAIL rtype_fetch: got %b want %b",
                {state, mif.imem_req, IRWrite, RegWriteEn}, {3'd0, 1'b1, 1'b1, 1'b0});
        end
        tick;
        tests++;
        if ({state, ctl} !== {3'd1, 22'd0}) begin
            fails++; $display("FAIL rtype_decode: got %b want %b", {state, ctl}, {3'd1, 22'd0});
        end
        tick;
        tests++;
        if ({state, ALUOP, ALUSrc, RegWriteEn, PCWrite} !== {3'd2, 2'b10, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL rtype_exec: got %b want %b",
                {state, ALUOP, ALUSrc, RegWriteEn, PCWrite}, {3'd2, 2'b10, 1'b0, 1'b0, 1'b0});
        end
        tick;
        tests++;
        if ({state, RegWriteEn, PCWrite, PCSrc, Mem2Reg} !== {3'd4, 1'b1, 1'b1, 2'b00, 1'b0}) begin
            fails++; $display("FAIL rtype_wb: got %b want %b",
                {state, RegWriteEn, PCWrite, PCSrc, Mem2Reg}, {3'd4, 1'b1, 1'b1, 2'b00, 1'b0});
        end
        tick;
        tests++;
        if ({state, PCWrite, RegWriteEn} !== {3'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL rtype_next: got %b want %b",
                {state, PCWrite, RegWriteEn}, {3'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_branch;
        logic [2:0] f3 [5];
        logic       z [5], lt [5], ltu [5];
        logic [1:0] want [5], want_l [5];
        f3 = '{3'b001, 3'b001, 3'b100, 3'b111, 3'b000};
        z = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        lt = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ltu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        want = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        want_l = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) begin
            selector = 5'b11000; funct3 = f3[i]; Zero = z[i]; Lt = lt[i]; Ltu = ltu[i];
            tick;
            tick;
            tests++;
            if ({state, Branch, ALUOP, PCWrite, PCSrc, ImmSel} !==
                {3'd2, 1'b1, 2'b01, 1'b1, want[i], 3'b010}) begin
                fails++; $display("FAIL branch_exec[%0d]: got %b want %b", i,
                    {state, Branch, ALUOP, PCWrite, PCSrc, ImmSel},
                    {3'd2, 1'b1, 2'b01, 1'b1, want[i], 3'b010});
            end
            tests++;
            if ({l_state, l_PCWrite, l_PCSrc} !== {3'd2, 1'b1, want_l[i]}) begin
                fails++; $display("FAIL branch_legacy[%0d]: got %b want %b", i,
                    {l_state, l_PCWrite, l_PCSrc}, {3'd2, 1'b1, want_l[i]});
            end
            tick;
            tests++;
            if ({state, PCWrite} !== {3'd0, 1'b0}) begin
                fails++; $display("FAIL branch_next[%0d]: got %b want %b", i,
                    {state, PCWrite}, {3'd0, 1'b0});
            end
        end
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; funct3 = 3'b000;
    endtask

    task automatic test_jumps;
        logic [4:0] sel [2];
        logic [1:0] pcs [2];
        logic       asrc [2];
        logic [2:0] imm [2];
        sel = '{5'b11011, 5'b11001}; pcs = '{2'b01, 2'b10};
        asrc = '{1'b0, 1'b1}; imm = '{3'b100, 3'b000};
        for (int i = 0; i < 2; i++) begin
            selector = sel[i];
            tick;
            tick;
            tests++;
            if ({state, Jump, WDSrc, RegWriteEn, PCWrite, PCSrc, ALUSrc, ImmSel} !==
                {3'd2, 1'b1, 1'b1, 1'b1, 1'b1, pcs[i], asrc[i], imm[i]}) begin
                fails++; $display("FAIL jump_exec[%0d]: got %b want %b", i,
                    {state, Jump, WDSrc, RegWriteEn, PCWrite, PCSrc, ALUSrc, ImmSel},
                    {3'd2, 1'b1, 1'b1, 1'b1, 1'b1, pcs[i], asrc[i], imm[i]});
            end
            tick;
        end
        sel = '{5'b01101, 5'b00101};
        for (int i = 0; i < 2; i++) begin
            selector = sel[i];
            tick;
            tick;
            tests++;
            if ({state, LUIOP, ASrcPC, ALUSrc, ImmSel, ALUOP} !==
                {3'd2, (i == 0), (i == 1), 1'b1, 3'b011, 2'b00}) begin
                fails++; $display("FAIL upper_exec[%0d]: got %b want %b", i,
                    {state, LUIOP, ASrcPC, ALUSrc, ImmSel, ALUOP},
                    {3'd2, (i == 0), (i == 1), 1'b1, 3'b011, 2'b00});
            end
            tick;
            tick;
        end
        tests++;
        if (state !== 3'd0) begin
            fails++; $display("FAIL upper_next: got %0d want 0", state);
        end
    endtask

    task automatic test_load_wait;
        selector = 5'b00000;
        tick;
        tick;
        tests++;
        if ({state, ALUSrc, ImmSel, ALUOP} !== {3'd2, 1'b1, 3'b000, 2'b00}) begin
            fails++; $display("FAIL load_exec: got %b want %b",
                {state, ALUSrc, ImmSel, ALUOP}, {3'd2, 1'b1, 3'b000, 2'b00});
        end
        mif.dmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (k == 3) mif.dmem_ready = 1'b1;
            #1;
            tests++;
            if ({state, mif.dmem_req, MemRead, MemWrite, PCWrite} !==
                {3'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                fails++; $display("FAIL load_mem[%0d]: got %b want %b", k,
                    {state, mif.dmem_req, MemRead, MemWrite, PCWrite},
                    {3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
            end
        end
        tick;
        tests++;
        if ({state, Mem2Reg, RegWriteEn, PCWrite, PCSrc, mif.dmem_req} !==
            {3'd4, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0}) begin
            fails++; $display("FAIL load_wb: got %b want %b",
                {state, Mem2Reg, RegWriteEn, PCWrite, PCSrc, mif.dmem_req},
                {3'd4, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        end
        tick;
        tests++;
        if (state !== 3'd0) begin
            fails++; $display("FAIL load_next: got %0d want 0", state);
        end
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_trap;
        int bad;
        selector = 5'b11111;
        tick;
        tick;
        tests++;
        if ({state, ctl} !== {3'd7, 22'd1}) begin
            fails++; $display("FAIL trap_enter: got %b want %b", {state, ctl}, {3'd7, 22'd1});
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if ({state, illegal} !== {3'd7, 1'b1}) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL trap_sticky: got %0d bad cycles want 0", bad);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({state, illegal} !== {3'd5, 1'b0}) begin
            fails++; $display("FAIL trap_reset: got %b want %b", {state, illegal}, {3'd5, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        selector = 5'b11000; funct3 = 3'b010;
        tick;
        tick;
        tests++;
        if ({state, illegal, l_state, l_illegal} !== {3'd7, 1'b1, 3'd2, 1'b0}) begin
            fails++; $display("FAIL trap_funct3: got %b want %b",
                {state, illegal, l_state, l_illegal}, {3'd7, 1'b1, 3'd2, 1'b0});
        end
        funct3 = 3'b000;
        pulse_reset();
    endtask

    task automatic test_timeout;
        int bad;
        selector = 5'b01100;
        mif.imem_ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            tick;
            if ({state, mif.imem_req} !== {3'd0, 1'b1}) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL timeout_wait: got %0d bad cycles want 0", bad);
        end
        tick;
        tests++;
        if ({state, illegal} !== {3'd7, 1'b1}) begin
            fails++; $display("FAIL timeout_trap: got %b want %b", {state, illegal}, {3'd7, 1'b1});
        end
        pulse_reset();
        for (int k = 0; k < 16; k++) tick;
        mif.imem_ready = 1'b1;
        #1;
        tests++;
        if ({state, IRWrite} !== {3'd0, 1'b1}) begin
            fails++; $display("FAIL timeout_edge_fetch: got %b want %b", {state, IRWrite}, {3'd0, 1'b1});
        end
        tick;
        tests++;
        if ({state, illegal} !== {3'd1, 1'b0}) begin
            fails++; $display("FAIL timeout_edge_decode: got %b want %b", {state, illegal}, {3'd1, 1'b0});
        end
        tick;
        tick;
        tick;
    endtask

    task automatic test_store_reset;
        selector = 5'b01000;
        mif.dmem_ready = 1'b0;
        tick;
        tick;
        tests++;
        if ({state, ImmSel, ALUSrc, ALUOP, MemWrite} !== {3'd2, 3'b001, 1'b1, 2'b00, 1'b0}) begin
            fails++; $display("FAIL store_exec: got %b want %b",
                {state, ImmSel, ALUSrc, ALUOP, MemWrite}, {3'd2, 3'b001, 1'b1, 2'b00, 1'b0});
        end
        tick;
        tests++;
        if ({state, mif.dmem_req, MemWrite, MemRead} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
            fails++; $display("FAIL store_mem: got %b want %b",
                {state, mif.dmem_req, MemWrite, MemRead}, {3'd3, 1'b1, 1'b1, 1'b0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({state, ctl} !== {3'd5, 22'd0}) begin
            fails++; $display("FAIL store_async_reset: got %b want %b", {state, ctl}, {3'd5, 22'd0});
        end
        mif.dmem_ready = 1'b1;
        tick;
        tests++;
        if ({state, ctl} !== {3'd5, 22'd0}) begin
            fails++; $display("FAIL store_no_pcwrite: got %b want %b", {state, ctl}, {3'd5, 22'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        tick;
        tick;
        tests++;
        if ({state, MemWrite, PCWrite, PCSrc, RegWriteEn} !== {3'd3, 1'b1, 1'b1, 2'b00, 1'b0}) begin
            fails++; $display("FAIL store_done: got %b want %b",
                {state, MemWrite, PCWrite, PCSrc, RegWriteEn}, {3'd3, 1'b1, 1'b1, 2'b00, 1'b0});
        end
        tick;
        tests++;
        if ({state, PCWrite} !== {3'd0, 1'b0}) begin
            fails++; $display("FAIL store_next: got %b want %b", {state, PCWrite}, {3'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_jumps();
        test_load_wait();
        test_trap();
        test_timeout();
        test_store_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
